ahb_burst_sequencer: RTL

Command-driven front end that feeds the UI port of ahb_master, i.e. its i_addr/i_size/i_wr/i_rd/i_min_len/i_cont/i_data/i_dav inputs, paced by its o_next.
- Accepts one burst command at a time (base address, beat count, size, direction) on a valid/ready channel.
- Streams write data from a valid/ready channel into the master, inserting BUSY beats when data is late.
- Forwards returned read data and pulses o_done when the command completes.

---
 rtl/ahb_burst_sequencer_pkg.sv | 22 ++
 rtl/ahb_burst_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ahb_burst_sequencer_pkg.sv
// rtl/ahb_burst_sequencer_pkg.sv - shared types for the AHB burst sequencer
package ahb_burst_sequencer_pkg;

  typedef enum logic [2:0] {
    BYTE     = 3'd0,
    HALFWORD = 3'd1,
    WORD     = 3'd2,
    DWORD    = 3'd3,
    QWORD    = 3'd4,
    OWORD    = 3'd5,
    W512     = 3'd6,
    W1024    = 3'd7
  } t_hsize;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } t_seq_state;

endpackage

// File: rtl/ahb_burst_sequencer.sv
// rtl/ahb_burst_sequencer.sv - command-driven burst front end for the ahb_master UI port
module ahb_burst_sequencer
  import ahb_burst_sequencer_pkg::*;
#(
  parameter int DATA_WDT = 32,
  parameter int BEAT_WDT = 32
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [31:0]         i_cmd_addr,
  input  logic [BEAT_WDT-1:0] i_cmd_len,
  input  t_hsize              i_cmd_size,
  input  logic                i_cmd_write,
  input  logic                i_wd_valid,
  output logic                o_wd_ready,
  input  logic [DATA_WDT-1:0] i_wd_data,
  output logic [31:0]         o_ui_addr,
  output t_hsize              o_ui_size,
  output logic                o_ui_wr,
  output logic                o_ui_rd,
  output logic [BEAT_WDT-1:0] o_ui_min_len,
  output logic                o_ui_cont,
  output logic [DATA_WDT-1:0] o_ui_data,
  output logic                o_ui_dav,
  input  logic                i_ui_next,
  input  logic [DATA_WDT-1:0] i_ui_rdata,
  input  logic [31:0]         i_ui_raddr,
  input  logic                i_ui_rdav,
  output logic                o_rvalid,
  output logic [DATA_WDT-1:0] o_rdata,
  output logic [31:0]         o_raddr,
  output logic                o_done
);

  localparam logic [BEAT_WDT-1:0] BEAT_ONE = BEAT_WDT'(1);

  t_seq_state          state;
  logic                write_q;
  logic [BEAT_WDT-1:0] rem;
  logic [BEAT_WDT-1:0] rcnt;
  logic [BEAT_WDT-1:0] len_q;
  logic                consumed;
  logic [BEAT_WDT-1:0] rem_after;

  // A presented beat is only real when it is a read or a write with data behind it.
  assign consumed    = i_ui_next && (o_ui_rd || (o_ui_wr && o_ui_dav));
  assign rem_after   = consumed ? (rem - BEAT_ONE) : rem;
  assign o_cmd_ready = (state == IDLE);
  assign o_wd_ready  = (state == ISSUE) && write_q && i_ui_next && (rem_after != '0);

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state        <= IDLE;
      write_q      <= 1'b0;
      rem          <= '0;
      rcnt         <= '0;
      len_q        <= '0;
      o_ui_addr    <= '0;
      o_ui_size    <= BYTE;
      o_ui_wr      <= 1'b0;
      o_ui_rd      <= 1'b0;
      o_ui_min_len <= '0;
      o_ui_cont    <= 1'b0;
      o_ui_data    <= '0;
      o_ui_dav     <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      // Read returns are counted up to the command length; stragglers are only forwarded.
      if ((state == ISSUE || state == RWAIT) && i_ui_rdav && (rcnt != len_q)) begin
        rcnt <= rcnt + BEAT_ONE;
      end
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            write_q <= i_cmd_write;
            rem     <= i_cmd_len;
            len_q   <= i_cmd_len;
            rcnt    <= '0;
            if (i_cmd_len == '0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              o_ui_addr    <= i_cmd_addr;
              o_ui_size    <= i_cmd_size;
              o_ui_min_len <= i_cmd_len;
              o_ui_cont    <= 1'b0;
              o_ui_rd      <= ~i_cmd_write;
              o_ui_wr      <= i_cmd_write;
              o_ui_dav     <= 1'b0;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (i_ui_next) begin
            if (consumed) begin
              rem       <= rem_after;
              o_ui_cont <= 1'b1;
            end
            if (write_q) begin
              // dav=0 with cont=1 shows BUSY; before the first beat it shows IDLE.
              if (rem_after != '0) begin
                o_ui_data <= i_wd_data;
                o_ui_dav  <= i_wd_valid;
              end else begin
                o_ui_wr   <= 1'b0;
                o_ui_cont <= 1'b0;
                o_ui_dav  <= 1'b0;
                state     <= DONE;
                o_done    <= 1'b1;
              end
            end else if (rem_after == '0) begin
              o_ui_rd   <= 1'b0;
              o_ui_cont <= 1'b0;
              state     <= RWAIT;
            end
          end
        end
        RWAIT: begin
          if (rcnt == len_q) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
      o_raddr  <= '0;
    end else begin
      o_rvalid <= i_ui_rdav;
      o_rdata  <= i_ui_rdata;
      o_raddr  <= i_ui_raddr;
    end
  end

endmodule
